excitation_sequencer: RTL

//  Controls the resolver excitation sine datapath: phase accumulator (DDS) plus amplitude envelope.

---
 rtl/excitation_pkg.sv | 17 +
 rtl/sample_tick_gen.sv | 27 ++
 rtl/excitation_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/excitation_pkg.sv
// Shared types and default widths for the resolver excitation sequencer.
package excitation_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RAMP_UP   = 2'd1,
      RUN       = 2'd2,
      RAMP_DOWN = 2'd3
   } exc_state_t;

   localparam int PHASE_W_DEF   = 16;
   localparam int ADDR_W_DEF    = 10;
   localparam int AMP_W_DEF     = 14;
   localparam int RAMP_STEP_DEF = 64;
   localparam int CLK_DIV_DEF   = 1;

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running prescaler: one-clock tick every CLK_DIV clocks (every clock when CLK_DIV = 1).
module sample_tick_gen #(
   parameter int CLK_DIV = 1
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] count;

   assign tick = (count == LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (tick) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/excitation_sequencer.sv
// Resolver excitation sequencer: DDS phase accumulator with a ramped amplitude envelope.
// FTW retunes are deferred to the phase wrap so the excitation phase never jumps.
module excitation_sequencer
   import excitation_pkg::*;
#(
   parameter int PHASE_W   = PHASE_W_DEF,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int AMP_W     = AMP_W_DEF,
   parameter int RAMP_STEP = RAMP_STEP_DEF,
   parameter int CLK_DIV   = CLK_DIV_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable_i,
   input  logic [AMP_W-1:0]   amp_target_i,
   input  logic [PHASE_W-1:0] ftw_i,
   input  logic               ftw_load_i,
   output logic [ADDR_W-1:0]  lut_addr_o,
   output logic [AMP_W-1:0]   amp_o,
   output logic               sample_valid_o,
   output logic               wrap_o,
   output logic               busy_o,
   output logic               ftw_pending_o,
   output logic [1:0]         state_dbg_o
);

   exc_state_t         state, state_nxt;
   logic               tick, tick_d, carry_q, apply_ftw;
   logic [AMP_W-1:0]   amp, amp_nxt, target;
   logic [PHASE_W-1:0] phase_acc, ftw_active, ftw_pend;
   logic [PHASE_W:0]   phase_sum;
   logic [AMP_W:0]     amp_up, amp_dn;

   sample_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   // Ramp arithmetic carries one extra bit so saturation can be detected instead of wrapping.
   assign phase_sum = {1'b0, phase_acc} + {1'b0, ftw_active};
   assign amp_up    = {1'b0, amp} + (AMP_W+1)'(RAMP_STEP);
   assign amp_dn    = {1'b0, amp} - (AMP_W+1)'(RAMP_STEP);
   assign apply_ftw = ftw_pending_o && ((state == IDLE) || (tick && phase_sum[PHASE_W]));

   assign busy_o      = (state != IDLE);
   assign state_dbg_o = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Outside IDLE the direction follows enable_i at each tick, so a reversal starts from the current amp.
   always_comb begin
      state_nxt = state;
      amp_nxt   = amp;
      if (tick) begin
         case (state)
            IDLE: begin
               if (enable_i) begin
                  state_nxt = RAMP_UP;
               end
            end
            default: begin
               if (enable_i) begin
                  amp_nxt   = (amp_up > {1'b0, target}) ? target : amp_up[AMP_W-1:0];
                  state_nxt = (amp_nxt == target) ? RUN : RAMP_UP;
               end else begin
                  amp_nxt   = amp_dn[AMP_W] ? '0 : amp_dn[AMP_W-1:0];
                  state_nxt = (amp_nxt == '0) ? IDLE : RAMP_DOWN;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         amp            <= '0;
         target         <= '0;
         phase_acc      <= '0;
         ftw_active     <= '0;
         ftw_pend       <= '0;
         ftw_pending_o  <= 1'b0;
         tick_d         <= 1'b0;
         carry_q        <= 1'b0;
         lut_addr_o     <= '0;
         amp_o          <= '0;
         sample_valid_o <= 1'b0;
         wrap_o         <= 1'b0;
      end else begin
         amp    <= amp_nxt;
         tick_d <= tick && (state != IDLE);
         if ((state == IDLE) && tick && enable_i) begin
            target <= amp_target_i;
         end
         if (tick && (state != IDLE)) begin
            carry_q   <= phase_sum[PHASE_W];
            phase_acc <= (state_nxt == IDLE) ? '0 : phase_sum[PHASE_W-1:0];
         end

         // A load coinciding with an apply keeps the new word pending.
         if (apply_ftw) begin
            ftw_active <= ftw_pend;
         end
         if (ftw_load_i) begin
            ftw_pend      <= ftw_i;
            ftw_pending_o <= 1'b1;
         end else if (apply_ftw) begin
            ftw_pending_o <= 1'b0;
         end

         sample_valid_o <= tick_d;
         wrap_o         <= tick_d && carry_q;
         if (tick_d) begin
            lut_addr_o <= phase_acc[PHASE_W-1 -: ADDR_W];
            amp_o      <= amp;
         end
      end
   end

endmodule
